// File: rtl/reversalmb_perlane_comparator.sv
// Receive-side per-lane ID comparator for MBINIT.REVERSALMB: counts word
// mismatches per lane over a fixed number of valid words, then latches a pass vector.
module reversalmb_perlane_comparator #(
  parameter int NUM_LANES     = 16,
  parameter int ITERATIONS    = 128,
  parameter int ERR_THRESHOLD = 16,
  parameter int CNT_W         = 8
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic [1:0]              i_Clear_Pattern_Comparator,
  input  logic [NUM_LANES*16-1:0] i_lane_data,
  input  logic                    i_data_valid,
  output logic [15:0]             o_REVERSAL_Result_logged,
  output logic                    o_compare_done,
  output logic                    o_result_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CLEAR   = 2'b01,
    ST_COMPARE = 2'b10,
    ST_DONE    = 2'b11
  } state_t;

  localparam logic [1:0]       MODE_CLEAR = 2'b01;
  localparam logic [1:0]       MODE_PLID  = 2'b11;
  localparam logic [CNT_W-1:0] ITER_LAST  = CNT_W'(ITERATIONS);
  // One extra bit so a threshold equal to 2^CNT_W still compares correctly.
  localparam logic [CNT_W:0]   THRESH     = (CNT_W+1)'(ERR_THRESHOLD);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     iter_q, iter_d, iter_inc;
  logic [CNT_W-1:0]     err_cnt_q [NUM_LANES];
  logic [CNT_W-1:0]     err_cnt_d [NUM_LANES];
  logic                 pend_q, pend_d;
  logic [15:0]          res_q, res_d;
  logic                 done_q, done_d;
  logic                 pulse_q, pulse_d;
  logic                 clr, cmp_en, latch;
  logic [NUM_LANES-1:0] lane_err;
  logic [15:0]          pass_vec;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam logic [7:0]  LANE_ID  = 8'(g);
    localparam logic [15:0] EXP_WORD = {4'b1010, LANE_ID, 4'b1010};
    assign lane_err[g] = (i_lane_data[16*g +: 16] != EXP_WORD);
  end

  // Mode follows the command each cycle; CLEAR overrides everything, DONE is sticky,
  // and a pending completion is latched regardless of the current mode.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    cmp_en  = 1'b0;
    latch   = 1'b0;
    if (i_Clear_Pattern_Comparator == MODE_CLEAR) begin
      state_d = ST_CLEAR;
      clr     = 1'b1;
    end else if (state_q == ST_DONE) begin
      state_d = ST_DONE;
    end else if (pend_q) begin
      state_d = ST_DONE;
      latch   = 1'b1;
    end else if (i_Clear_Pattern_Comparator == MODE_PLID) begin
      state_d = ST_COMPARE;
      cmp_en  = i_data_valid;
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    pass_vec = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      pass_vec[n] = ({1'b0, err_cnt_q[n]} < THRESH);
    end
  end

  assign iter_inc = iter_q + 1'b1;

  always_comb begin
    iter_d  = iter_q;
    pend_d  = pend_q;
    res_d   = res_q;
    done_d  = done_q;
    pulse_d = 1'b0;
    if (clr) begin
      iter_d = '0;
      pend_d = 1'b0;
      res_d  = '0;
      done_d = 1'b0;
    end else if (latch) begin
      pend_d  = 1'b0;
      res_d   = pass_vec;
      done_d  = 1'b1;
      pulse_d = 1'b1;
    end else if (cmp_en) begin
      iter_d = iter_inc;
      pend_d = (iter_inc == ITER_LAST);
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_LANES; n++) begin
      err_cnt_d[n] = err_cnt_q[n];
      if (clr) begin
        err_cnt_d[n] = '0;
      end else if (cmp_en && lane_err[n]) begin
        err_cnt_d[n] = sat_inc(err_cnt_q[n]);
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
      pend_q  <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
      pulse_q <= 1'b0;
      for (int n = 0; n < NUM_LANES; n++) begin
        err_cnt_q[n] <= '0;
      end
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      pend_q  <= pend_d;
      res_q   <= res_d;
      done_q  <= done_d;
      pulse_q <= pulse_d;
      for (int n = 0; n < NUM_LANES; n++) begin
        err_cnt_q[n] <= err_cnt_d[n];
      end
    end
  end

  assign o_REVERSAL_Result_logged = res_q;
  assign o_compare_done           = done_q;
  assign o_result_pulse           = pulse_q;

endmodule

// File: tb/tb_reversalmb_perlane_comparator.sv
// Bench for reversalmb_perlane_comparator: scenario tasks with a result scoreboard
// fed by a small behavioural model of the per-lane error counting.
module tb_reversalmb_perlane_comparator;

  localparam int ITER = 128;
  localparam int THR  = 16;

  logic         CLK = 1'b0;
  logic         rst_n;
  logic [1:0]   mode_i;
  logic [1:0]   mode8_i;
  logic         valid_i;
  logic [255:0] data_i;
  logic [15:0]  res_o, res8_o;
  logic         done_o, done8_o, pulse_o, pulse8_o;

  int n_checks = 0;
  int n_pass   = 0;

  int          m_err [16];
  int          m_iter;
  bit          m_done;
  logic [15:0] sb [$];
  logic [15:0] sb8 [$];

  reversalmb_perlane_comparator #(
    .NUM_LANES(16), .ITERATIONS(ITER), .ERR_THRESHOLD(THR), .CNT_W(8)
  ) dut (
    .CLK(CLK), .rst_n(rst_n),
    .i_Clear_Pattern_Comparator(mode_i),
    .i_lane_data(data_i),
    .i_data_valid(valid_i),
    .o_REVERSAL_Result_logged(res_o),
    .o_compare_done(done_o),
    .o_result_pulse(pulse_o)
  );

  reversalmb_perlane_comparator #(
    .NUM_LANES(8), .ITERATIONS(ITER), .ERR_THRESHOLD(THR), .CNT_W(8)
  ) dut8 (
    .CLK(CLK), .rst_n(rst_n),
    .i_Clear_Pattern_Comparator(mode8_i),
    .i_lane_data(data_i[127:0]),
    .i_data_valid(valid_i),
    .o_REVERSAL_Result_logged(res8_o),
    .o_compare_done(done8_o),
    .o_result_pulse(pulse8_o)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] exp_word(input int n);
    logic [7:0] id;
    id = 8'(n);
    return {4'b1010, id, 4'b1010};
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 16; n++) m_err[n] = 0;
    m_iter = 0;
    m_done = 1'b0;
  endtask

  // One clock: drive at negedge, let the posedge sample, advance the model.
  // bad[n] = 1 replaces lane n's word with 16'h0000.
  task automatic cycle(input logic [1:0] mode, input logic vld, input logic [15:0] bad);
    logic [15:0] v;
    @(negedge CLK);
    mode_i  = mode;
    valid_i = vld;
    for (int n = 0; n < 16; n++) data_i[16*n +: 16] = bad[n] ? 16'h0000 : exp_word(n);
    @(posedge CLK);
    #1;
    if (mode == 2'b01) begin
      model_reset();
    end else if (mode == 2'b11 && vld && !m_done) begin
      m_iter++;
      for (int n = 0; n < 16; n++) if (bad[n]) m_err[n]++;
      if (m_iter == ITER) begin
        v = '0;
        for (int n = 0; n < 16; n++) v[n] = (m_err[n] < THR);
        sb.push_back(v);
        m_done = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b1;
    mode_i  = 2'b11;
    mode8_i = 2'b00;
    valid_i = 1'b0;
    data_i  = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({res_o, done_o, pulse_o} !== 18'h0)
      $display("FAIL reset_outputs res=%h done=%b pulse=%b want 0000 0 0", res_o, done_o, pulse_o);
    else n_pass++;
    @(negedge CLK);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(2'b11, 1'b0, 16'h0);
    n_checks++;
    if (dut.iter_q !== 8'd0 || done_o !== 1'b0)
      $display("FAIL idle_bus iter=%0d done=%b want 0 0", dut.iter_q, done_o);
    else n_pass++;
  endtask

  task automatic test_all_clean();
    logic [15:0] exp;
    for (int i = 0; i < ITER; i++) begin
      cycle(2'b11, 1'b1, 16'h0);
      n_checks++;
      if ({done_o, pulse_o} !== 2'b00)
        $display("FAIL clean_early word=%0d done=%b pulse=%b want 0 0", i + 1, done_o, pulse_o);
      else n_pass++;
    end
    cycle(2'b11, 1'b0, 16'h0);
    n_checks++;
    if ({done_o, pulse_o} !== 2'b11)
      $display("FAIL clean_done done=%b pulse=%b want 1 1", done_o, pulse_o);
    else n_pass++;
    n_checks++;
    if (sb.size() == 0) $display("FAIL clean_result no expected entry, got %h", res_o);
    else begin
      exp = sb.pop_front();
      if (res_o !== exp) $display("FAIL clean_result got %h want %h", res_o, exp);
      else n_pass++;
    end
    cycle(2'b11, 1'b0, 16'h0);
    n_checks++;
    if ({done_o, pulse_o} !== 2'b10 || res_o !== 16'hFFFF)
      $display("FAIL clean_hold done=%b pulse=%b res=%h want 1 0 ffff", done_o, pulse_o, res_o);
    else n_pass++;
  endtask

  task automatic test_lane_errors();
    logic [15:0] bad, exp;
    cycle(2'b01, 1'b1, 16'hFFFF);
    n_checks++;
    if ({res_o, done_o} !== 17'h0)
      $display("FAIL lane_clear res=%h done=%b want 0000 0", res_o, done_o);
    else n_pass++;
    for (int i = 0; i < ITER; i++) begin
      bad = '0;
      if (i < 16) bad[3] = 1'b1;
      if (i >= 20 && i < 35) bad[7] = 1'b1;
      cycle(2'b11, 1'b1, bad);
    end
    n_checks++;
    if (dut.err_cnt_q[3] !== 8'(m_err[3]) || dut.err_cnt_q[7] !== 8'(m_err[7]))
      $display("FAIL lane_counts l3=%0d l7=%0d want %0d %0d",
               dut.err_cnt_q[3], dut.err_cnt_q[7], m_err[3], m_err[7]);
    else n_pass++;
    cycle(2'b11, 1'b0, 16'h0);
    n_checks++;
    if (sb.size() == 0 || pulse_o !== 1'b1)
      $display("FAIL lane_result no result pulse=%b res=%h", pulse_o, res_o);
    else begin
      exp = sb.pop_front();
      if (res_o !== exp) $display("FAIL lane_result got %h want %h", res_o, exp);
      else n_pass++;
    end
  endtask

  task automatic test_clear_midrun();
    logic [15:0] exp;
    cycle(2'b01, 1'b0, 16'h0);
    for (int i = 0; i < 60; i++) cycle(2'b11, 1'b1, 16'h0204);
    cycle(2'b01, 1'b1, 16'hFFFF);
    n_checks++;
    if (dut.iter_q !== 8'd0 || {res_o, done_o} !== 17'h0)
      $display("FAIL mid_clear iter=%0d res=%h done=%b want 0 0000 0", dut.iter_q, res_o, done_o);
    else n_pass++;
    for (int i = 0; i < ITER; i++) begin
      cycle(2'b11, 1'b1, 16'h0);
      n_checks++;
      if (done_o !== 1'b0) $display("FAIL mid_early word=%0d done=%b want 0", i + 1, done_o);
      else n_pass++;
    end
    cycle(2'b11, 1'b0, 16'h0);
    n_checks++;
    if (sb.size() == 0 || done_o !== 1'b1)
      $display("FAIL mid_result no result done=%b res=%h", done_o, res_o);
    else begin
      exp = sb.pop_front();
      if (res_o !== exp) $display("FAIL mid_result got %h want %h", res_o, exp);
      else n_pass++;
    end
  endtask

  task automatic test_pause();
    logic [15:0] exp;
    cycle(2'b01, 1'b0, 16'h0);
    for (int i = 0; i < 64; i++) cycle(2'b11, 1'b1, 16'h0);
    for (int i = 0; i < 20; i++) begin
      cycle((i < 10) ? 2'b00 : 2'b10, 1'b1, 16'hFFFF);
      n_checks++;
      if (done_o !== 1'b0 || dut.iter_q !== 8'd64)
        $display("FAIL pause_freeze cyc=%0d done=%b iter=%0d want 0 64", i, done_o, dut.iter_q);
      else n_pass++;
    end
    for (int i = 0; i < 64; i++) begin
      cycle(2'b11, 1'b1, 16'h0);
      n_checks++;
      if (done_o !== 1'b0) $display("FAIL pause_early word=%0d done=%b want 0", i + 65, done_o);
      else n_pass++;
    end
    cycle(2'b11, 1'b0, 16'h0);
    n_checks++;
    if (sb.size() == 0 || {done_o, pulse_o} !== 2'b11)
      $display("FAIL pause_result done=%b pulse=%b res=%h", done_o, pulse_o, res_o);
    else begin
      exp = sb.pop_front();
      if (res_o !== exp) $display("FAIL pause_result got %h want %h", res_o, exp);
      else n_pass++;
    end
  endtask

  task automatic test_after_done();
    logic [15:0] held;
    held = res_o;
    for (int i = 0; i < 50; i++) begin
      cycle(2'b11, 1'b1, 16'hFFFF);
      n_checks++;
      if ({done_o, pulse_o} !== 2'b10 || res_o !== held)
        $display("FAIL done_hold cyc=%0d done=%b pulse=%b res=%h want 1 0 %h",
                 i, done_o, pulse_o, res_o, held);
      else n_pass++;
    end
    cycle(2'b00, 1'b1, 16'hFFFF);
    n_checks++;
    if (done_o !== 1'b1 || res_o !== held)
      $display("FAIL done_mode00 done=%b res=%h want 1 %h", done_o, res_o, held);
    else n_pass++;
    cycle(2'b01, 1'b0, 16'h0);
    n_checks++;
    if ({res_o, done_o} !== 17'h0)
      $display("FAIL done_clear res=%h done=%b want 0000 0", res_o, done_o);
    else n_pass++;
  endtask

  task automatic test_narrow();
    logic [15:0] exp;
    mode8_i = 2'b11;
    for (int i = 0; i < ITER; i++) begin
      cycle(2'b00, 1'b1, 16'h0);
      if (i == ITER - 1) begin
        exp = '0;
        for (int n = 0; n < 8; n++) exp[n] = 1'b1;
        sb8.push_back(exp);
      end
    end
    cycle(2'b00, 1'b0, 16'h0);
    n_checks++;
    if (sb8.size() == 0 || {done8_o, pulse8_o} !== 2'b11)
      $display("FAIL narrow_done done=%b pulse=%b", done8_o, pulse8_o);
    else begin
      exp = sb8.pop_front();
      if (res8_o !== exp) $display("FAIL narrow_result got %h want %h", res8_o, exp);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < ITER + 1; i++) cycle(2'b11, 1'b1, 16'h0);
    void'(sb.pop_front());
    n_checks++;
    if (done_o !== 1'b1) $display("FAIL areset_pre done=%b want 1", done_o);
    else n_pass++;
    for (int i = 0; i < 30; i++) cycle(2'b01 + 2'b10, 1'b1, 16'h0);
    @(posedge CLK);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({res_o, done_o, pulse_o} !== 18'h0)
      $display("FAIL areset_main res=%h done=%b pulse=%b want 0000 0 0", res_o, done_o, pulse_o);
    else n_pass++;
    n_checks++;
    if ({res8_o, done8_o, pulse8_o} !== 18'h0)
      $display("FAIL areset_narrow res=%h done=%b pulse=%b want 0000 0 0", res8_o, done8_o, pulse8_o);
    else n_pass++;
    n_checks++;
    if (dut.iter_q !== 8'd0 || dut.err_cnt_q[0] !== 8'd0)
      $display("FAIL areset_cnt iter=%0d err0=%0d want 0 0", dut.iter_q, dut.err_cnt_q[0]);
    else n_pass++;
    model_reset();
    @(negedge CLK);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_all_clean();
    test_lane_errors();
    test_clear_midrun();
    test_pause();
    test_after_done();
    test_narrow();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
